// File: rtl/nco_pkg.sv
// Shared register map and bus-strobe types for the multi-channel phase NCO.
package nco_pkg;

    localparam logic [1:0] REG_FREQH = 2'd0;
    localparam logic [1:0] REG_FREQL = 2'd1;
    localparam logic [1:0] REG_PHASE = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_EN_BIT = 0;

    // One-hot register write strobes delivered to a single channel.
    typedef struct packed {
        logic freqh;
        logic freql;
        logic phase;
        logic ctrl;
    } ch_wr_t;

    // SYNC sits directly after the last channel's register block.
    function automatic logic [15:0] sync_offset(input int nch);
        return 16'(4 * nch);
    endfunction

endpackage

// File: rtl/nco_channel.sv
// One NCO channel: frequency registers, accumulator, tick-driven phase counter,
// phase offset (slewed when NCO_PHASE_SLEW_EN is defined) and registered phase address.
module nco_channel
    import nco_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  ch_wr_t           wr,
    input  logic [15:0]      wdata,
    output logic [CNT_W-1:0] cout,
    output logic             tick,
    output logic             busy
);

    logic [ACC_W-17:0] fwh_q, fwh_d;
    logic [ACC_W-1:0]  fw_q, fw_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W:0]    sum;
    logic              tick_q, tick_d;
    logic              ch_en_q, ch_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  ofs_q, ofs_d;
    logic [CNT_W-1:0]  cout_q, cout_d;
`ifdef NCO_PHASE_SLEW_EN
    localparam logic [CNT_W-1:0] HALF = {1'b1, {(CNT_W-1){1'b0}}};
    logic [CNT_W-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0]  diff;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
        fwh_d   = fwh_q;
        fw_d    = fw_q;
        ch_en_d = ch_en_q;
        acc_d   = acc_q;
        tick_d  = 1'b0;
        cnt_d   = cnt_q;
        ofs_d   = ofs_q;
        sum     = {1'b0, acc_q} + {1'b0, fw_q};

        if (wr.freqh) fwh_d   = wdata[ACC_W-17:0];
        if (wr.freql) fw_d    = {fwh_q, wdata};
        if (wr.ctrl)  ch_en_d = wdata[CTRL_EN_BIT];

        if (sync) begin
            acc_d = '0;
            cnt_d = '0;
        end else begin
            if (en && ch_en_q) begin
                acc_d  = sum[ACC_W-1:0];
                tick_d = sum[ACC_W];
            end
            // A tick registered before a stop still retires into the counter.
            if (tick_q) cnt_d = cnt_q + 1'b1;
        end

`ifdef NCO_PHASE_SLEW_EN
        tgt_d = wr.phase ? wdata[CNT_W-1:0] : tgt_q;
        diff  = tgt_q - ofs_q;
        if (sync) begin
            ofs_d = tgt_q;
        end else if (tick_q && diff != '0) begin
            // Modular shortest path; an exact half-turn resolves upward.
            ofs_d = (diff <= HALF) ? ofs_q + 1'b1 : ofs_q - 1'b1;
        end
        busy = (ofs_q != tgt_q);
`else
        if (wr.phase) ofs_d = wdata[CNT_W-1:0];
        busy = 1'b0;
`endif

        cout_d = cnt_q + ofs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwh_q   <= '0;
            fw_q    <= '0;
            ch_en_q <= 1'b1;
            acc_q   <= '0;
            tick_q  <= 1'b0;
            cnt_q   <= '0;
            ofs_q   <= '0;
            cout_q  <= '0;
`ifdef NCO_PHASE_SLEW_EN
            tgt_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbours.
            fwh_q   <= fwh_d;
            fw_q    <= fw_d;
            ch_en_q <= ch_en_d;
            acc_q   <= acc_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            ofs_q   <= ofs_d;
            cout_q  <= cout_d;
`ifdef NCO_PHASE_SLEW_EN
            tgt_q   <= tgt_d;
`endif
        end
    end

    assign cout = cout_q;
    assign tick = tick_q;

endmodule

// File: rtl/nco_phase_sync_multi.sv
// Multi-channel NCO top: bus address decode, global SYNC pulse and BUSY reduction.
// Optional phase slewing is enabled by defining NCO_PHASE_SLEW_EN.
module nco_phase_sync_multi
    import nco_pkg::*;
#(
    parameter int          NCH       = 2,
    parameter int          ACC_W     = 32,
    parameter int          CNT_W     = 10,
    parameter logic [15:0] BASE_ADDR = 16'h000A
) (
    input  logic                 CLK_BASE,
    input  logic                 RST,
    input  logic                 EN,
    input  logic                 CS,
    input  logic                 WR_EN,
    input  logic [15:0]          ADDR,
    input  logic [15:0]          WDATA,
    output logic [NCH*CNT_W-1:0] COUT,
    output logic [NCH-1:0]       TICK,
    output logic                 BUSY
);

    logic            wr_acc;
    logic [15:0]     offset;
    logic            sync;
    logic [NCH-1:0]  busy_ch;

    // Addresses below BASE_ADDR wrap to a large offset and fall outside the map.
    assign wr_acc = !CS && WR_EN;
    assign offset = ADDR - BASE_ADDR;
    assign sync   = wr_acc && (offset == sync_offset(NCH));

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic   sel;
        ch_wr_t wr;

        assign sel      = wr_acc && (offset[15:2] == 14'(k));
        assign wr.freqh = sel && (offset[1:0] == REG_FREQH);
        assign wr.freql = sel && (offset[1:0] == REG_FREQL);
        assign wr.phase = sel && (offset[1:0] == REG_PHASE);
        assign wr.ctrl  = sel && (offset[1:0] == REG_CTRL);

        nco_channel #(
            .ACC_W (ACC_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk   (CLK_BASE),
            .rst   (RST),
            .en    (EN),
            .sync  (sync),
            .wr    (wr),
            .wdata (WDATA),
            .cout  (COUT[k*CNT_W +: CNT_W]),
            .tick  (TICK[k]),
            .busy  (busy_ch[k])
        );
    end

    assign BUSY = |busy_ch;

endmodule

// File: tb/tb_nco_phase_sync_multi.sv
// Self-checking bench for nco_phase_sync_multi against a cycle-level arithmetic model.
module tb_nco_phase_sync_multi;

    localparam int               NCH   = 2;
    localparam int               ACC_W = 32;
    localparam int               CNT_W = 10;
    localparam logic [15:0]      BASE  = 16'h000A;
    localparam int               M     = 1 << CNT_W;
    localparam longint unsigned  AMOD  = 64'd1 << ACC_W;
    localparam longint unsigned  HMOD  = 64'd1 << (ACC_W - 16);

    logic                 CLK_BASE = 1'b0;
    logic                 RST, EN, CS, WR_EN;
    logic [15:0]          ADDR, WDATA;
    logic [NCH*CNT_W-1:0] COUT;
    logic [NCH-1:0]       TICK;
    logic                 BUSY;

    int tests = 0;
    int fails = 0;

    // Reference state: plain integers per channel.
    longint unsigned m_acc[NCH], m_fw[NCH], m_fwh[NCH];
    int              m_cnt[NCH], m_ofs[NCH], m_tgt[NCH], m_cout[NCH];
    bit              m_tick[NCH], m_en[NCH];

    always #5 CLK_BASE = ~CLK_BASE;

    nco_phase_sync_multi #(
        .NCH(NCH), .ACC_W(ACC_W), .CNT_W(CNT_W), .BASE_ADDR(BASE)
    ) dut (
        .CLK_BASE(CLK_BASE), .RST(RST), .EN(EN), .CS(CS), .WR_EN(WR_EN),
        .ADDR(ADDR), .WDATA(WDATA), .COUT(COUT), .TICK(TICK), .BUSY(BUSY)
    );

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_acc[k] = 0; m_fw[k] = 0; m_fwh[k] = 0;
            m_cnt[k] = 0; m_ofs[k] = 0; m_tgt[k] = 0; m_cout[k] = 0;
            m_tick[k] = 0; m_en[k] = 1;
        end
    endfunction

    function automatic logic [NCH*CNT_W-1:0] exp_cout();
        logic [NCH*CNT_W-1:0] r;
        for (int k = 0; k < NCH; k++) r[k*CNT_W +: CNT_W] = CNT_W'(m_cout[k]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_tick();
        logic [NCH-1:0] r;
        for (int k = 0; k < NCH; k++) r[k] = m_tick[k];
        return r;
    endfunction

    function automatic logic exp_busy();
        logic r = 1'b0;
`ifdef NCO_PHASE_SLEW_EN
        for (int k = 0; k < NCH; k++) if (m_ofs[k] != m_tgt[k]) r = 1'b1;
`endif
        return r;
    endfunction

    function automatic bit model_ok();
        return (COUT === exp_cout()) && (TICK === exp_tick()) && (BUSY === exp_busy());
    endfunction

    // Advance one clock: evaluate the model on the pre-edge inputs, clock, then settle.
    task automatic cycle();
        longint unsigned n_acc[NCH], n_fw[NCH], n_fwh[NCH], s;
        int n_cnt[NCH], n_ofs[NCH], n_tgt[NCH], n_cout[NCH];
        bit n_tick[NCH], n_en[NCH];
        bit wr;
        bit sync;
        int idx;
        int d;
        wr   = (CS === 1'b0) && (WR_EN === 1'b1);
        idx  = int'(ADDR) - int'(BASE);
        sync = wr && (idx == 4 * NCH);
        for (int k = 0; k < NCH; k++) begin
            n_acc[k] = m_acc[k]; n_fw[k] = m_fw[k]; n_fwh[k] = m_fwh[k];
            n_cnt[k] = m_cnt[k]; n_ofs[k] = m_ofs[k]; n_tgt[k] = m_tgt[k];
            n_en[k] = m_en[k]; n_tick[k] = 0;
            if (sync) begin
                n_acc[k] = 0; n_cnt[k] = 0;
`ifdef NCO_PHASE_SLEW_EN
                n_ofs[k] = m_tgt[k];
`endif
            end else begin
                if (EN && m_en[k]) begin
                    s = m_acc[k] + m_fw[k];
                    n_tick[k] = (s >= AMOD);
                    n_acc[k]  = s % AMOD;
                end
                if (m_tick[k]) n_cnt[k] = (m_cnt[k] + 1) % M;
`ifdef NCO_PHASE_SLEW_EN
                d = (m_tgt[k] - m_ofs[k] + M) % M;
                if (m_tick[k] && d != 0)
                    n_ofs[k] = (d <= M / 2) ? (m_ofs[k] + 1) % M : (m_ofs[k] + M - 1) % M;
`endif
            end
            n_cout[k] = (m_cnt[k] + m_ofs[k]) % M;
            if (wr && idx >= 0 && idx < 4 * NCH && idx / 4 == k) begin
                case (idx % 4)
                    0: n_fwh[k] = longint'(WDATA) % HMOD;
                    1: n_fw[k]  = m_fwh[k] * 65536 + longint'(WDATA);
`ifdef NCO_PHASE_SLEW_EN
                    2: n_tgt[k] = int'(WDATA) % M;
`else
                    2: n_ofs[k] = int'(WDATA) % M;
`endif
                    default: n_en[k] = WDATA[0];
                endcase
            end
        end
        @(posedge CLK_BASE);
        if (RST) begin
            model_reset();
        end else begin
            for (int k = 0; k < NCH; k++) begin
                m_acc[k] = n_acc[k]; m_fw[k] = n_fw[k]; m_fwh[k] = n_fwh[k];
                m_cnt[k] = n_cnt[k]; m_ofs[k] = n_ofs[k]; m_tgt[k] = n_tgt[k];
                m_cout[k] = n_cout[k]; m_tick[k] = n_tick[k]; m_en[k] = n_en[k];
            end
        end
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        ADDR = a; WDATA = d; CS = 1'b0; WR_EN = 1'b1;
        cycle();
        CS = 1'b1; WR_EN = 1'b0;
    endtask

    function automatic logic [15:0] reg_addr(input int k, input int j);
        return BASE + 16'(4 * k + j);
    endfunction

    task automatic set_fw(input int k, input logic [31:0] fw);
        bus_write(reg_addr(k, 0), fw[31:16]);
        bus_write(reg_addr(k, 1), fw[15:0]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (COUT !== '0 || TICK !== '0 || BUSY !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: cout=%h tick=%b busy=%b, want all zero", COUT, TICK, BUSY);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_tick_rate();
        int last = -1;
        int wraps = 0;
        logic [CNT_W-1:0] prev;
        set_fw(0, 32'h4000_0000);
        EN = 1'b1;
        prev = COUT[0 +: CNT_W];
        for (int i = 0; i < 4200; i++) begin
            cycle();
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL tick_rate_model: cout=%h/%h tick=%b/%b busy=%b/%b", COUT, exp_cout(), TICK, exp_tick(), BUSY, exp_busy());
            end
            if (TICK[0]) begin
                if (last >= 0) begin
                    tests++;
                    if (i - last != 4) begin
                        fails++;
                        $display("FAIL tick_interval: gap=%0d, want 4", i - last);
                    end
                end
                last = i;
            end
            if (prev == CNT_W'(M - 1) && COUT[0 +: CNT_W] == '0) wraps++;
            prev = COUT[0 +: CNT_W];
        end
        tests++;
        if (wraps != 1) begin
            fails++;
            $display("FAIL cout_wrap: saw %0d wraps 1023->0, want 1", wraps);
        end
    endtask

    task automatic test_freq_commit();
        int first = -1;
        bus_write(reg_addr(1, 0), 16'h1234);
        for (int i = 0; i < 10; i++) begin
            cycle();
            tests++;
            if (TICK[1] !== 1'b0 || !model_ok()) begin
                fails++;
                $display("FAIL freqh_staged_only: tick=%b/%b cout=%h/%h", TICK, exp_tick(), COUT, exp_cout());
            end
        end
        bus_write(reg_addr(1, 1), 16'h5678);
        for (int i = 1; i <= 20; i++) begin
            cycle();
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL freql_commit_model: tick=%b/%b cout=%h/%h", TICK, exp_tick(), COUT, exp_cout());
            end
            if (TICK[1] && first < 0) first = i;
        end
        tests++;
        if (first != 15) begin
            fails++;
            $display("FAIL freql_first_tick: first tick after %0d cycles, want 15", first);
        end
    endtask

    task automatic test_sync_phase();
        set_fw(0, 32'h2000_0000);
        set_fw(1, 32'h2000_0000);
        bus_write(reg_addr(1, 2), 16'd256);
        bus_write(BASE + 16'(4 * NCH), 16'hBEEF);
        tests++;
        if (TICK !== '0) begin
            fails++;
            $display("FAIL sync_tick_clear: tick=%b, want 0", TICK);
        end
        cycle();
        tests++;
        if (COUT[0 +: CNT_W] !== 10'd0 || COUT[CNT_W +: CNT_W] !== 10'd256) begin
            fails++;
            $display("FAIL sync_cout_ofs: cout0=%0d cout1=%0d, want 0 and 256", COUT[0 +: CNT_W], COUT[CNT_W +: CNT_W]);
        end
        for (int i = 0; i < 60; i++) begin
            cycle();
            tests++;
            if (CNT_W'(COUT[CNT_W +: CNT_W] - COUT[0 +: CNT_W]) !== 10'd256 || !model_ok()) begin
                fails++;
                $display("FAIL sync_phase_diff: cout=%h want %h, diff must be 256", COUT, exp_cout());
            end
        end
    endtask

    task automatic test_en_hold();
        logic [NCH*CNT_W-1:0] held;
        EN = 1'b0;
        cycle();
        cycle();
        held = COUT;
        for (int i = 0; i < 20; i++) begin
            cycle();
            tests++;
            if (TICK !== '0 || COUT !== held || !model_ok()) begin
                fails++;
                $display("FAIL en_hold: tick=%b cout=%h, want tick 0 cout %h", TICK, COUT, held);
            end
        end
        EN = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cycle();
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL en_resume: cout=%h/%h tick=%b/%b", COUT, exp_cout(), TICK, exp_tick());
            end
        end
    endtask

`ifdef NCO_PHASE_SLEW_EN
    task automatic test_slew();
        int n = 0;
        int i = 0;
        bus_write(reg_addr(0, 2), 16'd1020);
        tests++;
        if (BUSY !== 1'b1) begin
            fails++;
            $display("FAIL slew_busy_rise: busy=%b, want 1", BUSY);
        end
        while (BUSY === 1'b1 && i < 200) begin
            if (TICK[0]) n++;
            cycle();
            i++;
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL slew_model: cout=%h/%h busy=%b/%b", COUT, exp_cout(), BUSY, exp_busy());
            end
        end
        tests++;
        if (n != 4 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL slew_steps: %0d ticks while busy, busy=%b, want 4 and 0", n, BUSY);
        end
    endtask
`endif

    task automatic test_random();
        int r;
        for (int i = 0; i < 400; i++) begin
            EN = ($urandom_range(0, 9) != 0);
            r  = $urandom_range(0, 9);
            CS = 1'b1; WR_EN = 1'b0;
            ADDR = 16'($urandom); WDATA = 16'($urandom);
            if (r <= 5) begin
                ADDR = reg_addr($urandom_range(0, NCH - 1), $urandom_range(0, 3));
                if (ADDR[1:0] == (BASE[1:0] + 2'd3)) WDATA[0] = ($urandom_range(0, 3) != 0);
                CS = 1'b0; WR_EN = 1'b1;
            end else if (r == 6) begin
                ADDR = BASE + 16'(4 * NCH); CS = 1'b0; WR_EN = 1'b1;
            end else if (r == 7) begin
                ADDR = ($urandom_range(0, 1) != 0) ? BASE - 16'd1 : BASE + 16'(4 * NCH + 1 + $urandom_range(0, 50));
                CS = 1'b0; WR_EN = 1'b1;
            end else if (r == 8) begin
                ADDR = reg_addr(0, 1); WR_EN = 1'b1;
            end
            cycle();
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL random_model: addr=%h cout=%h/%h tick=%b/%b busy=%b/%b", ADDR, COUT, exp_cout(), TICK, exp_tick(), BUSY, exp_busy());
            end
        end
        CS = 1'b1; WR_EN = 1'b0; EN = 1'b1;
    endtask

    task automatic test_reset_mid();
        int first = -1;
        for (int i = 0; i < 5; i++) cycle();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        tests++;
        if (COUT !== '0 || TICK !== '0 || BUSY !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: cout=%h tick=%b busy=%b, want all zero", COUT, TICK, BUSY);
        end
        cycle();
        cycle();
        RST = 1'b0;
        EN = 1'b1;
        set_fw(0, 32'h4000_0000);
        for (int i = 1; i <= 10; i++) begin
            cycle();
            tests++;
            if (!model_ok()) begin
                fails++;
                $display("FAIL reset_resume_model: cout=%h/%h tick=%b/%b", COUT, exp_cout(), TICK, exp_tick());
            end
            if (TICK[0] && first < 0) first = i;
        end
        tests++;
        if (first != 4) begin
            fails++;
            $display("FAIL reset_ctrl_default: first tick after %0d cycles, want 4", first);
        end
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0; CS = 1'b1; WR_EN = 1'b0;
        ADDR = '0; WDATA = '0;
        model_reset();
        #1;
        test_reset();
        test_tick_rate();
        test_freq_commit();
        test_sync_phase();
        test_en_hold();
`ifdef NCO_PHASE_SLEW_EN
        test_slew();
`endif
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
